// File: rtl/logic_unit_stage_8_bits.sv
// Registered, handshaked 8-bit bitwise logic stage (AND/OR/XOR/NOT A).
// Optional accumulate mode plus a wrapping count of accepted results.
//
// state | meaning
// IDLE  | ready for a request; operands captured on IN_VALID
// EXEC  | computing; S and Z written on the next edge
// HOLD  | result presented with OUT_VALID until OUT_READY
module logic_unit_stage_8_bits (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [1:0] OP,
  input  logic       ACC,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] S,
  output logic       Z,
  output logic [7:0] OP_COUNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [1:0] op_r;
  logic       acc_r;
  logic [7:0] operand_x;
  logic [7:0] result;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    state_next = state;
    IN_READY   = 1'b0;
    OUT_VALID  = 1'b0;
    case (state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) state_next = EXEC;
      end
      EXEC: state_next = HOLD;
      HOLD: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    operand_x = acc_r ? S : b_r;
    result    = 8'h00;
    case (op_r)
      2'b00:   result = a_r & operand_x;
      2'b01:   result = a_r | operand_x;
      2'b10:   result = a_r ^ operand_x;
      default: result = ~a_r;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_r      <= 8'h00;
      b_r      <= 8'h00;
      op_r     <= 2'b00;
      acc_r    <= 1'b0;
      S        <= 8'h00;
      Z        <= 1'b0;
      OP_COUNT <= 8'h00;
    end else begin
      if (state == IDLE && IN_VALID) begin
        a_r   <= A;
        b_r   <= B;
        op_r  <= OP;
        acc_r <= ACC;
      end
      if (state == EXEC) begin
        S <= result;
        Z <= (result == 8'h00);
      end
      if (state == HOLD && OUT_READY) OP_COUNT <= OP_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_logic_unit_stage_8_bits.sv
// Scoreboard bench for logic_unit_stage_8_bits: expected results queued at
// request time, compared when the stage presents OUT_VALID.
module tb_logic_unit_stage_8_bits;

  logic       CLK;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] OP;
  logic       ACC;
  logic [7:0] A;
  logic [7:0] B;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] S;
  logic       Z;
  logic [7:0] OP_COUNT;

  logic_unit_stage_8_bits dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .ACC(ACC), .A(A), .B(B), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .S(S), .Z(Z), .OP_COUNT(OP_COUNT)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         prev_accept = -1;
  logic [8:0] exp_q[$];
  logic [7:0] s_model = 8'h00;
  logic [7:0] cnt_model = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [7:0] model_op(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] x);
    case (op)
      2'b00:   return a & x;
      2'b01:   return a | x;
      2'b10:   return a ^ x;
      default: return ~a;
    endcase
  endfunction

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic run_op(input logic [1:0] op, input logic acc, input logic [7:0] a,
                        input logic [7:0] b, input int stall, input bit chk_gap);
    logic [7:0] r;
    logic [8:0] e;
    int         lat;
    chk("in_ready_idle", IN_READY, 1);
    r = model_op(op, a, acc ? s_model : b);
    s_model = r;
    exp_q.push_back({(r == 8'h00), r});
    A = a; B = b; OP = op; ACC = acc; IN_VALID = 1'b1;
    @(negedge CLK);
    if (chk_gap && prev_accept >= 0) chk("accept_spacing", cyc - prev_accept, 3);
    prev_accept = cyc;
    IN_VALID = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    chk("in_ready_exec", IN_READY, 0);
    chk("out_valid_exec", OUT_VALID, 0);
    lat = 0;
    while (!OUT_VALID && lat < 8) begin
      @(negedge CLK);
      lat++;
    end
    chk("latency", lat, 1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("s", S, e[7:0]);
      chk("z", Z, e[8]);
    end
    for (int i = 0; i < stall; i++) begin
      IN_VALID = 1'b1;
      A = 8'($urandom); B = 8'($urandom); OP = 2'($urandom);
      @(negedge CLK);
      chk("stall_s", S, s_model);
      chk("stall_in_ready", IN_READY, 0);
      chk("stall_out_valid", OUT_VALID, 1);
      chk("stall_count", OP_COUNT, cnt_model);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    cnt_model = cnt_model + 8'd1;
    chk("op_count", OP_COUNT, cnt_model);
    chk("in_ready_after", IN_READY, 1);
    chk("out_valid_after", OUT_VALID, 0);
  endtask

  task automatic apply_reset(input int n);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    exp_q.delete();
    s_model = 8'h00;
    cnt_model = 8'h00;
    chk("rst_s", S, 8'h00);
    chk("rst_z", Z, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_op_count", OP_COUNT, 8'h00);
    chk("rst_in_ready", IN_READY, 1);
  endtask

  // phase 0: reset while in EXEC, phase 1: reset while in HOLD
  task automatic rst_mid(input int phase);
    A = 8'hF0; B = 8'h0F; OP = 2'b01; ACC = 1'b0; IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    if (phase == 1) begin
      @(negedge CLK);
      chk("pre_rst_out_valid", OUT_VALID, 1);
      OUT_READY = 1'b1;
    end
    apply_reset(1);
    OUT_READY = 1'b0;
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    OP = 2'b00; ACC = 1'b0; A = 8'h00; B = 8'h00;
    @(negedge CLK);
    apply_reset(2);

    run_op(2'b01, 1'b0, 8'h9D, 8'h9F, 0, 1'b0);
    run_op(2'b01, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    run_op(2'b00, 1'b0, 8'hFF, 8'hA9, 0, 1'b0);
    run_op(2'b10, 1'b0, 8'hFF, 8'hA9, 0, 1'b0);
    run_op(2'b11, 1'b1, 8'h0F, 8'h33, 0, 1'b0);

    run_op(2'b01, 1'b0, 8'h01, 8'h02, 0, 1'b0);
    run_op(2'b01, 1'b1, 8'h80, 8'hFF, 0, 1'b0);
    run_op(2'b00, 1'b1, 8'h0F, 8'hFF, 0, 1'b0);
    chk("acc_chain_s", S, 8'h03);

    run_op(2'b10, 1'b0, 8'h5A, 8'h3C, 5, 1'b0);

    rst_mid(0);
    run_op(2'b00, 1'b0, 8'hC3, 8'h81, 0, 1'b0);
    rst_mid(1);
    run_op(2'b10, 1'b0, 8'h12, 8'h34, 0, 1'b0);

    apply_reset(1);
    prev_accept = -1;
    for (int i = 0; i < 256; i++)
      run_op(2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1);
    chk("count_wrap", OP_COUNT, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
